// File: rtl/skew_feed_pkg.sv
// Shared types and default sizes for the skew-feed controller.
// Holds the controller state enum and default parameter values.
package skew_feed_pkg;

  localparam int DEF_N          = 4;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/feed_counter.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
// Ports: clk, rst_n (sync, low), load/load_val, en, count, zero.
module feed_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && !zero)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/skew_feed_controller.sv
// Feeds num_vec buffer vectors into an N-lane skew chain, then N-1 zeros.
// Ports: start handshake + cfg, stall, buffer read, skew_en/feed_valid, busy/done.
module skew_feed_controller
  import skew_feed_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [LEN_WIDTH-1:0]  cfg_num_vec,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                  stall,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  output logic                  skew_en,
  output logic                  feed_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = $clog2(N) + 1;

  state_t state, state_nxt;
  logic   vld_q;
  logic   [ADDR_WIDTH-1:0] addr_q;
  logic   hs, adv, rd_en, in_feed, in_drain;
  logic   vec_zero, drn_zero, drn_load;
  logic   [LEN_WIDTH-1:0] unused_vec_cnt;
  logic   [DW-1:0]        unused_drn_cnt;

  assign in_feed  = (state == FEED);
  assign in_drain = (state == DRAIN);
  assign adv      = (in_feed || in_drain) && !stall;
  assign rd_en    = in_feed && !stall;
  assign hs       = start_valid && start_ready;
  assign drn_load = rd_en && vec_zero;

  // Outputs are gated by rst_n so they read 0 while reset is held.
  assign start_ready = rst_n && (state == IDLE);
  assign busy        = rst_n && (state != IDLE);
  assign done        = rst_n && (state == DONE);
  assign buf_rd_en   = rst_n && rd_en;
  assign feed_valid  = rst_n && vld_q && !stall;
  assign skew_en     = rst_n && (vld_q || in_drain) && !stall;
  assign buf_rd_addr = rst_n ? addr_q : '0;

  // Holds reads remaining minus one; zero marks the last read.
  feed_counter #(.W(LEN_WIDTH)) u_vec_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hs),
    .load_val (cfg_num_vec - 1'b1),
    .en       (rd_en),
    .count    (unused_vec_cnt),
    .zero     (vec_zero)
  );

  // Counts the N drain cycles down to zero.
  feed_counter #(.W(DW)) u_drn_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (drn_load),
    .load_val (DW'(N - 1)),
    .en       (in_drain && adv),
    .count    (unused_drn_cnt),
    .zero     (drn_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      vld_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (adv)
        vld_q <= rd_en;
      if (hs)
        addr_q <= cfg_base_addr;
      else if (rd_en)
        addr_q <= addr_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (hs)
          state_nxt = (cfg_num_vec == '0) ? DONE : FEED;
      FEED:
        if (adv && vec_zero)
          state_nxt = DRAIN;
      DRAIN:
        if (adv && drn_zero)
          state_nxt = DONE;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/skew_feed_controller.md
SKEW_FEED_CONTROLLER -- requirements
Module: skew_feed_controller

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension, equal to the skew-register lane count.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of the vector count.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10: input-buffer address width.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port start_valid, input, 1: job request.
REQ-007 SHALL have port start_ready, output, 1: controller can accept a job.
REQ-008 SHALL have port cfg_num_vec, input, LEN_WIDTH: number of vectors to feed; sampled on handshake.
REQ-009 SHALL have port cfg_base_addr, input, ADDR_WIDTH: first buffer address; sampled on handshake.
REQ-010 SHALL have port stall, input, 1: downstream back-pressure; freezes the pipeline.
REQ-011 SHALL have port buf_rd_en, output, 1: buffer read strobe; the buffer has 1-cycle read latency and holds its output while buf_rd_en is low.
REQ-012 SHALL have port buf_rd_addr, output, ADDR_WIDTH: buffer read address.
REQ-013 SHALL have port skew_en, output, 1: enable to the skew registers and array.
REQ-014 SHALL have port feed_valid, output, 1: skew-register input is buffer data; when low, downstream injects zeros.
REQ-015 SHALL have port busy, output, 1: job in progress.
REQ-016 SHALL have port done, output, 1: one-cycle job-complete pulse.

Function
REQ-017 SHALL implement the states IDLE, FEED, DRAIN and DONE.
REQ-018 start_ready SHALL be high only in IDLE; a handshake occurs when start_valid and start_ready are both high, and it latches the config.
REQ-019 On handshake with cfg_num_vec > 0, the next state SHALL be FEED; with cfg_num_vec = 0, the next state SHALL be DONE, and skew_en and buf_rd_en SHALL never assert.
REQ-020 Define adv = (FEED or DRAIN) and not stall; all counters, the state and vld_q SHALL update only when adv is high (DONE and IDLE ignore stall).
REQ-021 In FEED, buf_rd_en SHALL equal adv, and buf_rd_addr SHALL be base + k for the k-th read, k = 0..num_vec-1.
REQ-022 The address SHALL wrap modulo 2^ADDR_WIDTH.
REQ-023 After the num_vec-th read is issued, the state SHALL go to DRAIN.
REQ-024 vld_q SHALL be a register loaded with buf_rd_en when adv is high.
REQ-025 feed_valid SHALL be vld_q and not stall.
REQ-026 skew_en SHALL be (vld_q or DRAIN) and not stall.
REQ-027 DRAIN SHALL last N unstalled cycles: the first carries the last vector, and the remaining N-1 inject zeros; the state then goes to DONE.
REQ-028 DONE SHALL last exactly 1 cycle with done high, then go to IDLE.
REQ-029 Unstalled timing with the handshake at cycle 0: reads at cycles 1..num_vec; data skew_en at cycles 2..num_vec+1; zero skew_en at cycles num_vec+2..num_vec+N; done at cycle num_vec+N+1.
REQ-030 Total skew_en-high cycles SHALL equal num_vec + N - 1.
REQ-031 busy SHALL be high in FEED, DRAIN and DONE.
REQ-032 busy SHALL be low in IDLE.
REQ-033 start_valid while busy SHALL be ignored and not queued.
REQ-034 cfg_num_vec = 2^LEN_WIDTH - 1 SHALL be supported without counter overflow.
REQ-035 stall held for any number of cycles SHALL lose no vector and duplicate none.

Reset
REQ-036 When rst_n is low at a rising clock edge, the controller SHALL go to IDLE, clear vld_q, clear the counters and clear the config registers, from any state including mid-job.
REQ-037 During reset, buf_rd_en, skew_en, feed_valid, busy and done SHALL all be 0, start_ready SHALL be 0, and buf_rd_addr SHALL be 0.
REQ-038 start_ready SHALL rise in the first cycle after rst_n returns high.

Structure
REQ-039 Package skew_feed_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-040 One sub-module, feed_counter, SHALL be used twice: the vector counter and the drain counter. It is a loadable down-counter with enable and zero flag.

Verification
REQ-041 N=4, num_vec=3, base=5, no stall -> reads at addresses 5,6,7 in cycles 1-3; skew_en at cycles 2-7; feed_valid at cycles 2-4; done at cycle 8.
REQ-042 num_vec=0 -> done at cycle 1; skew_en and buf_rd_en never high.
REQ-043 num_vec=4 with stall high at cycles 3-5 -> all outputs frozen; done at cycle 12; the sequence of data seen at skew_en equals addresses base..base+3.
REQ-044 base = 2^ADDR_WIDTH - 2, num_vec=4 -> addresses max-1, max, 0, 1.
REQ-045 rst_n low during DRAIN -> next cycle in IDLE; all outputs per REQ-037; start_ready high after release; a new job then runs correctly.
REQ-046 start_valid held high continuously -> jobs run back-to-back, with each new handshake accepted only in the IDLE cycle following done.
